ring_meter: RTL

Controller and frequency meter for the NCL ring oscillator. It sequences the ring's NCL `init`: holds it, releases it, and waits for the ring to settle. It then counts edges of a divided ring clock over a fixed window of the 25 MHz board clock and reports the count. If the ring deadlocks it is re-initialised automatically. The block sits between the board-clock domain (buttons, LEDs, I/O) and the asynchronous ring, replacing free-running LED display of the divided clock.

---
 rtl/ring_meter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ring_meter.sv
// ring_meter: init sequencer and frequency meter for the NCL ring oscillator.
// Holds the ring in init, releases it, lets it settle, then counts edges of
// the divided ring clock over a fixed window of the board clock. A ring that
// stops producing edges during a window is re-initialised automatically.
module ring_meter #(
  parameter int INIT_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int GATE_CYCLES   = 2500000,
  parameter int STALL_CYCLES  = 256,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 24
) (
  input  logic             clk_25mhz,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             async_div,
  output logic             ring_init,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             stalled,
  output logic [7:0]       restarts
);

  // One phase counter times INIT, SETTLE and the MEASURE window, so it must
  // hold the longest of the three.
  localparam int PHASE_MAX = (GATE_CYCLES > INIT_CYCLES) ?
                             ((GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES) :
                             ((INIT_CYCLES > SETTLE_CYCLES) ? INIT_CYCLES : SETTLE_CYCLES);
  localparam int PHASE_W = $clog2(PHASE_MAX + 1);
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, INIT, SETTLE, MEASURE, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic               s1;
  logic               s2;
  logic               s3;
  logic               ring_edge;
  logic               stall_hit;
  logic [PHASE_W-1:0] phase;
  logic [STALL_W-1:0] stall_timer;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W:0]   retry_inc;
  logic [CNT_W-1:0]   acc;
  logic [CNT_W-1:0]   acc_inc;

  // Edge detect, saturating accumulator step and stall condition for this cycle.
  always_comb begin
    ring_edge = s2 & ~s3;
    acc_inc   = acc;
    if (ring_edge && (acc != {CNT_W{1'b1}})) begin
      acc_inc = acc + 1'b1;
    end
    retry_inc = {1'b0, retry} + 1'b1;
    stall_hit = (state == MEASURE) && !ring_edge &&
                (stall_timer == STALL_W'(STALL_CYCLES - 1));
  end

  // State register.
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a stall takes priority over the end of the window.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = INIT;
      INIT:    if (phase == PHASE_W'(INIT_CYCLES - 1)) state_next = SETTLE;
      SETTLE:  if (phase == PHASE_W'(SETTLE_CYCLES - 1)) state_next = MEASURE;
      MEASURE: begin
        if (stall_hit) begin
          state_next = (retry_inc < (RETRY_W + 1)'(MAX_RETRY)) ? INIT : IDLE;
        end else if (phase == PHASE_W'(GATE_CYCLES - 1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = continuous ? MEASURE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Synchroniser, timers, accumulator and the registered result/status outputs.
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      phase       <= '0;
      stall_timer <= '0;
      retry       <= '0;
      acc         <= '0;
      count       <= '0;
      stalled     <= 1'b0;
      restarts    <= 8'd0;
    end else begin
      s1 <= async_div;
      s2 <= s1;
      s3 <= s2;

      if (state_next != state) begin
        phase <= '0;
      end else if (state == INIT || state == SETTLE || state == MEASURE) begin
        phase <= phase + 1'b1;
      end

      if (state == MEASURE && state_next == MEASURE) begin
        stall_timer <= ring_edge ? '0 : stall_timer + 1'b1;
      end else begin
        stall_timer <= '0;
      end

      if (state == MEASURE) begin
        acc <= acc_inc;
      end else begin
        acc <= '0;
      end

      if (state == MEASURE && state_next == DONE) begin
        count <= acc_inc;
      end

      if (state == IDLE && state_next == INIT) begin
        retry   <= '0;
        stalled <= 1'b0;
      end else if (stall_hit) begin
        retry   <= retry_inc[RETRY_W-1:0];
        stalled <= 1'b1;
      end else if (state == DONE) begin
        retry   <= '0;
      end

      if (stall_hit && (restarts != 8'hFF)) begin
        restarts <= restarts + 8'd1;
      end
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    ring_init   = (state == IDLE) || (state == INIT);
    busy        = (state != IDLE);
    count_valid = (state == DONE);
  end

endmodule
